// File: rtl/rv_fetch_pkg.sv
// Shared types and constants for the RV32I instruction fetch front end.
package rv_fetch_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_BOOT,
    S_RUN,
    S_DRAIN
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO holding fetched {pc, instr} pairs for decode.
module fetch_fifo
  import rv_fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  fetch_entry_t             din,
  output fetch_entry_t             head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  fetch_entry_t    mem [DEPTH];
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic            do_push;
  logic            do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC generation, credit-limited imem requests, redirect
// handling with stale-response draining, and buffering toward decode.
module instr_fetch_unit
  import rv_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instruct,
  output logic [31:0] pc_out
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_X = (CW+1)'(DEPTH);

  fetch_state_t    state, state_nxt;
  logic [31:0]     fetch_pc, fetch_pc_nxt;
  logic [CW-1:0]   outstanding, outstanding_nxt;
  logic [CW-1:0]   drop_cnt, drop_cnt_nxt;
  logic [31:0]     pcq [DEPTH];
  logic [PW-1:0]   pcq_wr, pcq_rd;
  logic [CW-1:0]   count;
  logic            empty;
  logic            fifo_full_unused;
  logic            unused_pc_bits;
  fetch_entry_t    head, push_entry;
  logic            req_fire, rsp_fire, push, pop, flush, credit_ok;

  assign unused_pc_bits = ^redirect_pc[1:0];

  // Buffered entries count against credit so a returning response always has room.
  assign credit_ok      = ({1'b0, outstanding} + {1'b0, count}) < DEPTH_X;
  assign imem_req_valid = (state == S_RUN) && credit_ok;
  assign imem_addr      = fetch_pc;
  assign req_fire       = imem_req_valid & imem_req_ready;
  assign rsp_fire       = imem_rsp_valid & (outstanding != '0);
  assign pop            = instr_valid & instr_ready;
  assign push_entry     = '{pc: pcq[pcq_rd], instr: imem_rsp_data};

  always_comb begin
    state_nxt       = state;
    fetch_pc_nxt    = fetch_pc;
    drop_cnt_nxt    = drop_cnt;
    push            = 1'b0;
    flush           = 1'b0;
    outstanding_nxt = outstanding + CW'(req_fire) - CW'(rsp_fire);
    case (state)
      S_BOOT:  state_nxt = S_RUN;
      S_RUN: begin
        if (req_fire) fetch_pc_nxt = fetch_pc + 32'd4;
        push = rsp_fire;
      end
      S_DRAIN: begin
        if (rsp_fire) begin
          drop_cnt_nxt = drop_cnt - CW'(1);
          if (drop_cnt == CW'(1)) state_nxt = S_RUN;
        end
      end
      default: state_nxt = S_BOOT;
    endcase
    if (redirect_valid) begin
      fetch_pc_nxt = {redirect_pc[31:2], 2'b00};
      flush        = 1'b1;
      push         = 1'b0;
      drop_cnt_nxt = outstanding_nxt;
      state_nxt    = (outstanding_nxt != '0) ? S_DRAIN : S_RUN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_BOOT;
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
      pcq_wr      <= '0;
      pcq_rd      <= '0;
    end else begin
      state       <= state_nxt;
      fetch_pc    <= fetch_pc_nxt;
      outstanding <= outstanding_nxt;
      drop_cnt    <= drop_cnt_nxt;
      if (redirect_valid) begin
        pcq_wr <= '0;
        pcq_rd <= '0;
      end else begin
        if (req_fire) pcq_wr <= pcq_wr + PW'(1);
        if (rsp_fire && state == S_RUN) pcq_rd <= pcq_rd + PW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (req_fire && !redirect_valid) pcq[pcq_wr] <= fetch_pc;
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .din   (push_entry),
    .head  (head),
    .count (count),
    .empty (empty),
    .full  (fifo_full_unused)
  );

  assign instr_valid = ~empty;
  assign instruct    = empty ? NOP_INSTR : head.instr;
  assign pc_out      = empty ? 32'h0 : head.pc;

  rsp_tracked_a: assert property (@(posedge clk) disable iff (!rst_n)
    imem_rsp_valid |-> (outstanding != '0));

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Front stage of the RV32I core: holds the PC, issues word fetches to instruction memory, and buffers the returned words.
- Presents {instruct, pc} with a valid/ready handshake to the decode stage (signext, control, register file).
- Accepts redirects (taken branch/jump) from execute and discards stale in-flight fetches.
- Tolerates variable instruction-memory latency.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset
- DEPTH, 2, instruction buffer entries and max outstanding requests (power of 2, ≥2)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  imem accepts request
- imem_addr  out  32  fetch address, word aligned
- imem_rsp_valid  in  1  fetch data valid; responses in request order, no backpressure
- imem_rsp_data  in  32  fetched instruction word
- redirect_valid  in  1  execute redirect strobe
- redirect_pc  in  32  redirect target; bits [1:0] ignored, forced 0
- instr_valid  out  1  buffer head valid
- instr_ready  in  1  decode consumes head
- instruct  out  32  head instruction; 32'h0000_0013 (NOP) when empty
- pc_out  out  32  PC of head; 0 when empty

Behaviour:
- Async reset (rst_n=0), all outputs and state take reset values immediately:
  - fetch_pc=RESET_PC, state=S_BOOT
  - outstanding=0, drop_cnt=0, buffer empty
  - imem_req_valid=0, imem_addr=RESET_PC
  - instr_valid=0, instruct=NOP, pc_out=0
- FSM:
  - S_BOOT: no request; go to S_RUN next cycle.
  - S_RUN: imem_req_valid=1 iff outstanding + count < DEPTH. imem_addr=fetch_pc.
    - On req handshake: outstanding+1, fetch_pc += 4 (modulo 2^32; 0xFFFF_FFFC wraps to 0).
  - S_DRAIN: imem_req_valid=0. Each rsp decrements drop_cnt and outstanding; data discarded. When drop_cnt reaches 0, go to S_RUN.
- Responses in S_RUN: push {fetch-order pc, imem_rsp_data}, outstanding-1. A push cannot overflow, by the credit rule. Pc of each entry is captured at request time in a DEPTH-deep address queue.
- Latency: request at cycle N with response at N+L gives instr_valid at N+L+1 (buffer registered). Minimum boot-to-first-valid is 3 cycles with L=1.
- Consume: instr_valid & instr_ready pops head. Push and pop in the same cycle are both honoured, count unchanged.
- Redirect (any state except S_BOOT, which treats it identically):
  - fetch_pc←{redirect_pc[31:2],2'b00}; buffer flushed; address queue cleared.
  - drop_cnt←outstanding after this cycle's req/rsp events.
  - Next state: S_DRAIN if that value ≠0, else S_RUN.
- Simultaneous events with a redirect:
  - Redirect and pop: pop completes, then flush.
  - Redirect and rsp_valid: response dropped and counted against outstanding.
  - Redirect and req handshake: that request is included in drop_cnt.
  - Redirect during S_DRAIN: fetch_pc updated, drop_cnt←outstanding, stay in or leave S_DRAIN by the same rule.
- rsp_valid with outstanding=0 is a protocol error: ignored, and an assertion fires in simulation.
- Reset mid-operation: all state cleared asynchronously. In-flight responses after reset release are not tracked; imem is reset in the same domain.

Decomposition:
- Package rv_fetch_pkg holds:
  - NOP_INSTR=32'h0000_0013 and XLEN=32
  - fetch_state_t enum {S_BOOT, S_RUN, S_DRAIN}
  - fetch_entry_t struct {pc, instr}
- One sub-module, fetch_fifo: DEPTH-entry synchronous FIFO of fetch_entry_t.
  - Ports: push, pop, flush, count, head, empty/full.
  - Async active-low reset.
- Credit counting, the FSM and the PC queue live in instr_fetch_unit.

Test Plan:
- Boot, L=1, instr_ready=1: first instr_valid in cycle 3 with pc_out=0; then pc_out 0,4,8,… one per cycle; instruct matches memory words.
- instr_ready=0 with DEPTH=2: exactly 2 requests issued (addr 0,4), then imem_req_valid=0. Releasing ready yields pc 0,4, then a request at addr 8.
- imem_req_ready low for 5 cycles: imem_addr held at the same value and fetch_pc not advanced. instruct=NOP and instr_valid=0 throughout.
- Redirect to 0x0000_0102 with 2 outstanding (L=3): state S_DRAIN; both responses discarded; next request addr=0x0000_0100; next delivered pc_out=0x100.
- Redirect in the same cycle as a head pop and an rsp_valid: the popped instruction is seen by decode once, the response is dropped, and the buffer is empty next cycle.
- Wrap: RESET_PC=0xFFFF_FFF8 gives requests at 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000. Assert rst_n low mid-stream: all outputs reach reset values with no clock edge.
